// File: rtl/matmul_operand_fetch.sv
// rtl/matmul_operand_fetch.sv - operand fetch sequencer for the C = Y*X multiply-accumulate stage
//
// Polls the start flag in the shared working RAM, reads the packed dimension
// word, then walks Y (M x K) and X (K x N) and emits one operand pair per
// handshake in row-major-of-C, inner-k order. The start flag is cleared
// after the final pair.
//
// Optional build macro: MATMUL_FETCH_BOUND_CHECK_EN adds a CHECK state after
// HDR that rejects matrix shapes whose X region overlaps Y or whose Y region
// runs past the top of memory.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   en_i                 enables polling of the start flag
//   ram_addr_o/read_o/we_o/din_o, ram_dout_i
//                        single-port RAM master; dout is combinational
//   op_valid_o/op_ready_i, op_a_o (Y[i][k]), op_b_o (X[k][j])
//   op_first_k_o/op_last_k_o/op_last_o
//                        pair position flags for the accumulator
//   busy_o, done_o (pulse on flag clear), err_o (sticky)
module matmul_operand_fetch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned DIM_ADDR   = 1,
  parameter int unsigned X_BASE     = 2,
  parameter int unsigned Y_BASE     = 10002
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_read_o,
  output logic                  ram_we_o,
  output logic [31:0]           ram_din_o,
  input  logic [31:0]           ram_dout_i,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  output logic [31:0]           op_a_o,
  output logic [31:0]           op_b_o,
  output logic                  op_first_k_o,
  output logic                  op_last_k_o,
  output logic                  op_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DIM_A   = ADDR_WIDTH'(DIM_ADDR);
  localparam logic [ADDR_WIDTH-1:0] X_A     = ADDR_WIDTH'(X_BASE);
  localparam logic [ADDR_WIDTH-1:0] Y_A     = ADDR_WIDTH'(Y_BASE);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
`ifdef MATMUL_FETCH_BOUND_CHECK_EN
    S_CHECK,
`endif
    S_FETCH_Y,
    S_FETCH_X,
    S_OUT,
    S_CLEAR,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic                    ram_read_q, ram_we_q;
  logic                    op_valid_q, op_first_k_q, op_last_k_q, op_last_q;
  logic [31:0]             op_a_q, op_b_q;
  logic                    busy_q, done_q, err_q;
  logic [7:0]              m_q, k_q, n_q;
  logic [7:0]              i_q, j_q, kk_q;
  logic [ADDR_WIDTH-1:0]   y_row_q, y_addr_q, x_addr_q;

  logic [7:0]              i_d, j_d, kk_d;
  logic [ADDR_WIDTH-1:0]   y_row_d, y_addr_d, x_addr_d;
  logic                    k_wrap, j_wrap, i_wrap, hdr_bad;

  assign k_wrap = (kk_q == k_q - 8'd1);
  assign j_wrap = (j_q == n_q - 8'd1);
  assign i_wrap = (i_q == m_q - 8'd1);

  assign hdr_bad = (ram_dout_i[23:16] != ram_dout_i[15:8]) || (ram_dout_i[31:24] == 8'd0) ||
                   (ram_dout_i[23:16] == 8'd0) || (ram_dout_i[7:0] == 8'd0);

  // Next counter/address values, built from adds only: the address path
  // steps along a Y row / X column and rewinds at the k and j wraps.
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q + 8'd1;
    y_row_d  = y_row_q;
    y_addr_d = y_addr_q + ONE_A;
    x_addr_d = x_addr_q + ADDR_WIDTH'(n_q);
    if (k_wrap) begin
      kk_d = 8'd0;
      if (!j_wrap) begin
        j_d      = j_q + 8'd1;
        y_addr_d = y_row_q;
        x_addr_d = X_A + ADDR_WIDTH'(j_q) + ONE_A;
      end else begin
        j_d      = 8'd0;
        i_d      = i_q + 8'd1;
        y_row_d  = y_row_q + ADDR_WIDTH'(k_q);
        y_addr_d = y_row_q + ADDR_WIDTH'(k_q);
        x_addr_d = X_A;
      end
    end
  end

`ifdef MATMUL_FETCH_BOUND_CHECK_EN
  logic [15:0] kn_prod, mk_prod;
  logic        bound_bad;
  always_comb begin
    kn_prod   = 16'(k_q) * 16'(n_q);
    mk_prod   = 16'(m_q) * 16'(k_q);
    bound_bad = (64'(X_BASE) + 64'(kn_prod) > 64'(Y_BASE)) ||
                (64'(Y_BASE) + 64'(mk_prod) > (64'd1 << ADDR_WIDTH));
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ram_addr_q   <= '0;
      ram_read_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      op_valid_q   <= 1'b0;
      op_first_k_q <= 1'b0;
      op_last_k_q  <= 1'b0;
      op_last_q    <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      m_q          <= '0;
      k_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      kk_q         <= '0;
      y_row_q      <= '0;
      y_addr_q     <= '0;
      x_addr_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Outputs are registered, so the flag is only trusted on a cycle
          // where the read of START_ADDR is actually being presented.
          ram_read_q <= en_i;
          ram_addr_q <= START_A;
          if (ram_read_q && ram_dout_i[0]) begin
            state_q    <= S_HDR;
            ram_read_q <= 1'b1;
            ram_addr_q <= DIM_A;
            busy_q     <= 1'b1;
          end
        end
        S_HDR: begin
          m_q      <= ram_dout_i[31:24];
          k_q      <= ram_dout_i[23:16];
          n_q      <= ram_dout_i[7:0];
          i_q      <= '0;
          j_q      <= '0;
          kk_q     <= '0;
          y_row_q  <= Y_A;
          y_addr_q <= Y_A;
          x_addr_q <= X_A;
          if (hdr_bad) begin
            state_q    <= S_ERR;
            ram_read_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
          end else begin
`ifdef MATMUL_FETCH_BOUND_CHECK_EN
            state_q    <= S_CHECK;
            ram_read_q <= 1'b0;
`else
            state_q    <= S_FETCH_Y;
            ram_addr_q <= Y_A;
`endif
          end
        end
`ifdef MATMUL_FETCH_BOUND_CHECK_EN
        S_CHECK: begin
          if (bound_bad) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q    <= S_FETCH_Y;
            ram_read_q <= 1'b1;
            ram_addr_q <= y_addr_q;
          end
        end
`endif
        S_FETCH_Y: begin
          op_a_q     <= ram_dout_i;
          ram_addr_q <= x_addr_q;
          state_q    <= S_FETCH_X;
        end
        S_FETCH_X: begin
          op_b_q       <= ram_dout_i;
          ram_read_q   <= 1'b0;
          op_valid_q   <= 1'b1;
          op_first_k_q <= (kk_q == 8'd0);
          op_last_k_q  <= k_wrap;
          op_last_q    <= k_wrap && j_wrap && i_wrap;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (op_ready_i) begin
            op_valid_q   <= 1'b0;
            op_first_k_q <= 1'b0;
            op_last_k_q  <= 1'b0;
            op_last_q    <= 1'b0;
            i_q          <= i_d;
            j_q          <= j_d;
            kk_q         <= kk_d;
            y_row_q      <= y_row_d;
            y_addr_q     <= y_addr_d;
            x_addr_q     <= x_addr_d;
            if (op_last_q) begin
              state_q    <= S_CLEAR;
              ram_we_q   <= 1'b1;
              ram_addr_q <= START_A;
            end else begin
              state_q    <= S_FETCH_Y;
              ram_read_q <= 1'b1;
              ram_addr_q <= y_addr_d;
            end
          end
        end
        S_CLEAR: begin
          ram_we_q <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          // Wait for the host to drop en so a held en cannot re-trigger.
          if (!en_i) state_q <= S_IDLE;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr_o   = ram_addr_q;
  assign ram_read_o   = ram_read_q;
  assign ram_we_o     = ram_we_q;
  assign ram_din_o    = '0;
  assign op_valid_o   = op_valid_q;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign op_first_k_o = op_first_k_q;
  assign op_last_k_o  = op_last_k_q;
  assign op_last_o    = op_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
